// File: rtl/jk_pkg.sv
// Shared FSM states, per-bit {J,K} excitation codes and the mapping function
// used by the JK excitation driver.
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_CHECK   = 2'd3
    } state_t;

    // Codes are packed as {J, K}
    localparam logic [1:0] EXC_HOLD   = 2'b00;
    localparam logic [1:0] EXC_SET    = 2'b10;
    localparam logic [1:0] EXC_RESET  = 2'b01;
    localparam logic [1:0] EXC_TOGGLE = 2'b11;

    localparam int         CNT_W   = 4;
    localparam logic [7:0] ERR_MAX = 8'hFF;

    function automatic logic [1:0] exc_code(input logic cur, input logic tgt,
                                            input logic use_toggle);
        if (cur == tgt) return EXC_HOLD;
        if (use_toggle) return EXC_TOGGLE;
        return tgt ? EXC_SET : EXC_RESET;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational per-bit excitation map: (current, target) -> (J, K) for a
// WIDTH-bit flop array, in set/reset or toggle coding.
module jk_excite
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_tgt,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [1:0] w_code;
        assign w_code = exc_code(i_cur[b], i_tgt[b], USE_TOGGLE);
        assign o_j[b] = w_code[1];
        assign o_k[b] = w_code[0];
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external JK flop array to a requested state: hold excitation for
// PULSE cycles, release one cycle, then read back and report the result.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PULSE      = 1,
    parameter bit USE_TOGGLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_state,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             match,
    output logic [7:0]       err_count
);

    if (PULSE < 1 || PULSE > 15) begin : g_bad_pulse
        $error("PULSE must be in 1..15");
    end

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_tgt;
    logic [WIDTH-1:0]   w_j;
    logic [WIDTH-1:0]   w_k;
    logic               w_accept;

    // Excitation is computed from the values being latched so that j/k are
    // already valid in the first DRIVE cycle while still coming from flops.
    jk_excite #(
        .WIDTH      (WIDTH),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_excite (
        .i_cur (q_fb),
        .i_tgt (req_state),
        .o_j   (w_j),
        .o_k   (w_k)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_ready && req_valid;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tgt <= req_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            j         <= '0;
            k         <= '0;
            done      <= 1'b0;
            match     <= 1'b0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        j       <= w_j;
                        k       <= w_k;
                        r_cnt   <= '0;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == PULSE_LAST) begin
                        j       <= '0;
                        k       <= '0;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    done  <= 1'b1;
                    match <= (q_fb == r_tgt);
                    if ((q_fb != r_tgt) && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 8'd1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: three configurations, each with a JK flop
// array model on its outputs and a timeline-based reference model.
module tb_jk_excitation_driver;

    localparam int N = 3;
    localparam int PP [N] = '{1, 3, 1};
    localparam bit TG [N] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst;
    logic       vld  [N];
    logic [3:0] rs   [N];
    logic       rdy  [N];
    logic [3:0] jj   [N];
    logic [3:0] kk   [N];
    logic [3:0] fq   [N];
    logic       dn   [N];
    logic       mt   [N];
    logic [7:0] ec   [N];

    logic       ld    [N];
    logic [3:0] ldv   [N];
    logic [3:0] stuck [N];

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    jk_excitation_driver #(.WIDTH(4), .PULSE(1), .USE_TOGGLE(1'b0)) u0 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_state(rs[0]), .j(jj[0]), .k(kk[0]), .q_fb(fq[0]),
        .done(dn[0]), .match(mt[0]), .err_count(ec[0]));

    jk_excitation_driver #(.WIDTH(4), .PULSE(3), .USE_TOGGLE(1'b0)) u1 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_state(rs[1]), .j(jj[1]), .k(kk[1]), .q_fb(fq[1]),
        .done(dn[1]), .match(mt[1]), .err_count(ec[1]));

    jk_excitation_driver #(.WIDTH(4), .PULSE(1), .USE_TOGGLE(1'b1)) u2 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_state(rs[2]), .j(jj[2]), .k(kk[2]), .q_fb(fq[2]),
        .done(dn[2]), .match(mt[2]), .err_count(ec[2]));

    // External JK flop arrays: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits
    logic [3:0] fnext;
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ld[i]) fnext = ldv[i];
            else       fnext = (jj[i] & ~fq[i]) | (~kk[i] & fq[i]);
            fq[i] <= fnext & ~stuck[i];
        end
    end

    // Reference model: phase = edges since acceptance, -1 when idle
    int         ph   [N] = '{-1, -1, -1};
    logic [3:0] mtgt [N];
    logic [3:0] xj   [N];
    logic [3:0] xk   [N];
    logic [3:0] ej   [N];
    logic [3:0] ek   [N];
    logic       erdy [N];
    logic       edn  [N];
    logic       emt  [N];
    int         eerr [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                ph[i] = -1; edn[i] = 1'b0; emt[i] = 1'b0; eerr[i] = 0;
            end else begin
                edn[i] = 1'b0;
                if (ph[i] >= 0) begin
                    ph[i] = ph[i] + 1;
                    if (ph[i] == PP[i] + 2) begin
                        edn[i] = 1'b1;
                        emt[i] = (fq[i] == mtgt[i]);
                        if (!emt[i] && eerr[i] < 255) eerr[i] = eerr[i] + 1;
                        ph[i] = -1;
                    end
                end else if (vld[i]) begin
                    mtgt[i] = rs[i];
                    if (TG[i]) begin
                        xj[i] = fq[i] ^ rs[i];
                        xk[i] = fq[i] ^ rs[i];
                    end else begin
                        xj[i] = ~fq[i] & rs[i];
                        xk[i] = fq[i] & ~rs[i];
                    end
                    ph[i] = 0;
                end
            end
            ej[i]   = (ph[i] >= 0 && ph[i] < PP[i]) ? xj[i] : 4'h0;
            ek[i]   = (ph[i] >= 0 && ph[i] < PP[i]) ? xk[i] : 4'h0;
            erdy[i] = (ph[i] == -1);
        end
    end

    task automatic chk(input string nm, input int i, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] @%0t: got %0h want %0h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < N; i++) begin
                chk("j", i, 8'(jj[i]), 8'(ej[i]));
                chk("k", i, 8'(kk[i]), 8'(ek[i]));
                chk("req_ready", i, 8'(rdy[i]), 8'(erdy[i]));
                chk("done", i, 8'(dn[i]), 8'(edn[i]));
                chk("match", i, 8'(mt[i]), 8'(emt[i]));
                chk("err_count", i, ec[i], 8'(eerr[i]));
            end
        end
    end

    task automatic load(input int i, input logic [3:0] v);
        ld[i] = 1'b1; ldv[i] = v;
        @(posedge clk); #2;
        ld[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [3:0] s);
        bit ok = 1'b0;
        vld[i] = 1'b1; rs[i] = s;
        for (int c = 0; c < 20; c++) begin
            if (rdy[i]) begin
                ok = 1'b1;
                @(posedge clk); #2;
                break;
            end
            @(posedge clk); #2;
        end
        vld[i] = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout[%0d]: got no acceptance want acceptance", i);
        end
    endtask

    task automatic wait_done(input int i, output int lat, output logic [3:0] j0,
                             output logic [3:0] k0);
        lat = -1; j0 = 4'hx; k0 = 4'hx;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin j0 = jj[i]; k0 = kk[i]; end
            if (dn[i]) begin lat = c; break; end
        end
        total++;
        if (lat < 0) begin
            bad++;
            $display("FAIL done_timeout[%0d]: got no done want done", i);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         acc;
        int         seen;
        logic [3:0] j0, k0;

        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0; rs[i] = 4'h0; ld[i] = 1'b1; ldv[i] = 4'h0; stuck[i] = 4'h0;
        end
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < N; i++) ld[i] = 1'b0;
        started = 1'b1;

        // Reset values
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_ready", i, 8'(rdy[i]), 8'd1);
            chk("rst_j", i, 8'(jj[i]), 8'd0);
            chk("rst_done", i, 8'(dn[i]), 8'd0);
            chk("rst_err", i, ec[i], 8'd0);
        end

        // Set/reset coding, PULSE=1: 0101 -> 0011
        load(0, 4'b0101);
        send(0, 4'b0011);
        wait_done(0, lat, j0, k0);
        chk("sr_j", 0, 8'(j0), 8'b0010);
        chk("sr_k", 0, 8'(k0), 8'b0100);
        chk("sr_latency", 0, 8'(lat), 8'd3);
        chk("sr_match", 0, 8'(mt[0]), 8'd1);
        chk("sr_q", 0, 8'(fq[0]), 8'b0011);

        // Toggle coding: 1100 -> 1010
        load(2, 4'b1100);
        send(2, 4'b1010);
        wait_done(2, lat, j0, k0);
        chk("tg_j", 2, 8'(j0), 8'b0110);
        chk("tg_k", 2, 8'(k0), 8'b0110);
        chk("tg_match", 2, 8'(mt[2]), 8'd1);

        // No-change request, PULSE=3
        load(1, 4'b1111);
        send(1, 4'b1111);
        wait_done(1, lat, j0, k0);
        chk("nc_j", 1, 8'(j0), 8'd0);
        chk("nc_k", 1, 8'(k0), 8'd0);
        chk("nc_latency", 1, 8'(lat), 8'd5);
        chk("nc_match", 1, 8'(mt[1]), 8'd1);

        // Reset during the second DRIVE cycle, PULSE=3
        load(1, 4'b0000);
        send(1, 4'b1111);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_j", 1, 8'(jj[1]), 8'd0);
        chk("mid_rst_k", 1, 8'(kk[1]), 8'd0);
        chk("mid_rst_ready", 1, 8'(rdy[1]), 8'd1);
        chk("mid_rst_err", 1, ec[1], 8'd0);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dn[1]) seen++;
        end
        chk("mid_rst_no_done", 1, 8'(seen), 8'd0);

        // Continuous req_valid with a changing req_state
        acc = 0;
        vld[1] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            if (rdy[1]) acc++;
            rs[1] = 4'(c * 7 + 3);
        end
        vld[1] = 1'b0;
        chk("b2b_accepts", 1, 8'(acc), 8'd10);
        wait_done(1, lat, j0, k0);

        // Fault injection: bit 0 stuck at 0
        stuck[0] = 4'b0001;
        load(0, 4'b0000);
        send(0, 4'b0001);
        wait_done(0, lat, j0, k0);
        chk("flt_match", 0, 8'(mt[0]), 8'd0);
        chk("flt_err1", 0, ec[0], 8'd1);
        for (int n = 2; n <= 300; n++) begin
            send(0, 4'b0001);
            wait_done(0, lat, j0, k0);
            if (n == 255) chk("flt_err255", 0, ec[0], 8'd255);
        end
        chk("flt_err_sat", 0, ec[0], 8'd255);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
